// File: rtl/i2s_tx.sv
// I2S transmitter: takes strobed mono samples and sends the top SAMPLE_BITS of each
// one, MSB first and duplicated onto both channels of a 64-slot frame.
module i2s_tx #(
    parameter int DATA_WIDTH  = 32,
    parameter int SAMPLE_BITS = 24,
    parameter int CLK_DIV     = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sample_valid,
    input  logic signed [DATA_WIDTH-1:0] audio_in,
    output logic                         i2s_bclk,
    output logic                         i2s_lrclk,
    output logic                         i2s_sdata,
    output logic                         sample_req,
    output logic                         underrun,
    output logic                         overflow
);

    localparam int               DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0]       div;
    logic [5:0]             slot;
    logic [5:0]             next_slot;
    logic [SAMPLE_BITS-1:0] frame_reg;
    logic [SAMPLE_BITS-1:0] pending;
    logic                   pending_full;
    logic                   div_last;
    logic                   fall;
    logic                   frame_start;
    logic                   next_sdata;
    logic [31:0]            word;
    logic                   unused_lsbs;

    assign unused_lsbs = ^audio_in;

    // The sample is left-aligned below a leading zero so channel slot c reads word[31-c];
    // slot 0 and slots past the sample fall on zero padding.
    always_comb begin
        div_last    = (div == DIV_LAST);
        fall        = div_last && i2s_bclk;
        frame_start = fall && (slot == 6'd63);
        next_slot   = slot + 6'd1;
        word        = 32'(frame_reg) << (31 - SAMPLE_BITS);
        next_sdata  = word[~next_slot[4:0]];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div          <= '0;
            i2s_bclk     <= 1'b0;
            i2s_lrclk    <= 1'b1;
            i2s_sdata    <= 1'b0;
            sample_req   <= 1'b0;
            underrun     <= 1'b0;
            overflow     <= 1'b0;
            slot         <= 6'd63;
            frame_reg    <= '0;
            pending      <= '0;
            pending_full <= 1'b0;
        end else begin
            sample_req <= 1'b0;
            underrun   <= 1'b0;
            overflow   <= 1'b0;

            if (div_last) begin
                div      <= '0;
                i2s_bclk <= ~i2s_bclk;
            end else begin
                div <= div + 1'b1;
            end

            if (fall) begin
                slot      <= next_slot;
                i2s_lrclk <= next_slot[5];
                i2s_sdata <= next_sdata;
            end

            // Once consumed, pending still equals frame_reg, so loading it
            // unconditionally also covers the hold-on-underrun case.
            if (frame_start) begin
                frame_reg    <= pending;
                sample_req   <= 1'b1;
                underrun     <= ~pending_full;
                pending_full <= sample_valid;
            end else if (sample_valid) begin
                overflow     <= pending_full;
                pending_full <= 1'b1;
            end

            if (sample_valid) begin
                pending <= audio_in[DATA_WIDTH-1 -: SAMPLE_BITS];
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: a frame-level reference model checked every cycle,
// plus directed scenarios with hand-computed serial words.
module tb_i2s_tx;

    localparam int DW    = 32;
    localparam int SB    = 24;
    localparam int CD    = 4;
    localparam int FRAME = 128 * CD;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 sample_valid = 1'b0;
    logic signed [DW-1:0] audio_in = '0;
    logic                 i2s_bclk;
    logic                 i2s_lrclk;
    logic                 i2s_sdata;
    logic                 sample_req;
    logic                 underrun;
    logic                 overflow;

    int check_count = 0;
    int pass_count  = 0;
    bit running     = 1'b1;

    int          t = 0;
    logic [SB-1:0] m_pending = '0;
    logic [SB-1:0] m_frame   = '0;
    bit          m_full    = 1'b0;
    bit          exp_req   = 1'b0;
    bit          exp_under = 1'b0;
    bit          exp_ovf   = 1'b0;
    bit          fs;

    int   cmp_k;
    int   cmp_slot;
    int   cmp_c;
    logic exp_sdata;
    logic exp_bclk;
    logic exp_lrclk;

    i2s_tx #(
        .DATA_WIDTH (DW),
        .SAMPLE_BITS(SB),
        .CLK_DIV    (CD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sample_valid(sample_valid),
        .audio_in    (audio_in),
        .i2s_bclk    (i2s_bclk),
        .i2s_lrclk   (i2s_lrclk),
        .i2s_sdata   (i2s_sdata),
        .sample_req  (sample_req),
        .underrun    (underrun),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Frame-level model: edge t after release is a frame start when t mod FRAME == 2*CD.
    initial begin
        forever begin
            @(posedge clk);
            if (!reset) begin
                t = 0;
                m_pending = '0;
                m_frame = '0;
                m_full = 1'b0;
                exp_req = 1'b0;
                exp_under = 1'b0;
                exp_ovf = 1'b0;
            end else begin
                t++;
                fs = ((t % FRAME) == 2 * CD);
                exp_req = fs;
                exp_under = 1'b0;
                exp_ovf = 1'b0;
                if (fs) begin
                    m_frame = m_pending;
                    exp_under = !m_full;
                    m_full = sample_valid;
                end else if (sample_valid) begin
                    exp_ovf = m_full;
                    m_full = 1'b1;
                end
                if (sample_valid) begin
                    m_pending = audio_in[DW-1 -: SB];
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (running) begin
                if (!reset) begin
                    checkOutput("rst_bclk", 32'(i2s_bclk), 32'd0);
                    checkOutput("rst_lrclk", 32'(i2s_lrclk), 32'd1);
                    checkOutput("rst_sdata", 32'(i2s_sdata), 32'd0);
                    checkOutput("rst_req", 32'(sample_req), 32'd0);
                    checkOutput("rst_underrun", 32'(underrun), 32'd0);
                    checkOutput("rst_overflow", 32'(overflow), 32'd0);
                end else begin
                    cmp_k = t / (2 * CD);
                    cmp_slot = (cmp_k == 0) ? 63 : (cmp_k - 1) % 64;
                    cmp_c = cmp_slot % 32;
                    exp_bclk = ((t / CD) % 2) == 1;
                    exp_lrclk = cmp_slot >= 32;
                    exp_sdata = (cmp_k > 0 && cmp_c >= 1 && cmp_c <= SB) ? m_frame[SB-cmp_c] : 1'b0;
                    checkOutput("bclk", 32'(i2s_bclk), 32'(exp_bclk));
                    checkOutput("lrclk", 32'(i2s_lrclk), 32'(exp_lrclk));
                    checkOutput("sdata", 32'(i2s_sdata), 32'(exp_sdata));
                    checkOutput("sample_req", 32'(sample_req), 32'(exp_req));
                    checkOutput("underrun", 32'(underrun), 32'(exp_under));
                    checkOutput("overflow", 32'(overflow), 32'(exp_ovf));
                end
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] value);
        sample_valid = 1'b1;
        audio_in = value;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
    endtask

    task automatic waitFrame();
        for (int i = 0; i < 3 * FRAME && !sample_req; i++) begin
            @(posedge clk);
            #1;
        end
        if (!sample_req) begin
            checkOutput("frame_timeout", 32'(sample_req), 32'd1);
        end
    endtask

    // Collects one frame as two words with channel slot c at bit 31-c.
    task automatic captureFrame(input bit exp_underrun, input logic [31:0] exp_word, input string tag);
        logic [31:0] left;
        logic [31:0] right;
        waitFrame();
        checkOutput({tag, "_underrun"}, 32'(underrun), 32'(exp_underrun));
        left = '0;
        right = '0;
        for (int s = 0; s < 64; s++) begin
            if (s < 32) left[31-s] = i2s_sdata;
            else        right[63-s] = i2s_sdata;
            repeat (2 * CD) @(posedge clk);
            #1;
        end
        checkOutput({tag, "_left"}, left, exp_word);
        checkOutput({tag, "_right"}, right, exp_word);
    endtask

    task automatic checkStartup(input string tag);
        repeat (2 * CD - 1) @(posedge clk);
        #1;
        checkOutput({tag, "_req_early"}, 32'(sample_req), 32'd0);
        @(posedge clk);
        #1;
        checkOutput({tag, "_req_at8"}, 32'(sample_req), 32'd1);
        checkOutput({tag, "_under_at8"}, 32'(underrun), 32'd1);
        checkOutput({tag, "_lrclk_at8"}, 32'(i2s_lrclk), 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        checkStartup("start");

        repeat (255) @(posedge clk);
        #1;
        checkOutput("lrclk_low_end", 32'(i2s_lrclk), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("lrclk_rise", 32'(i2s_lrclk), 32'd1);

        captureFrame(1'b1, 32'h0000_0000, "silent");

        applyStimulus(32'h7FFF_FF00);
        captureFrame(1'b0, 32'h3FFF_FF80, "max");

        applyStimulus(32'h8000_0000);
        captureFrame(1'b0, 32'h4000_0000, "min");
        captureFrame(1'b1, 32'h4000_0000, "repeat");

        applyStimulus(32'h1234_5600);
        checkOutput("ovf_first", 32'(overflow), 32'd0);
        repeat (10) @(posedge clk);
        #1;
        applyStimulus(32'hABCD_EF00);
        checkOutput("ovf_second", 32'(overflow), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("ovf_single", 32'(overflow), 32'd0);
        captureFrame(1'b0, 32'h55E6_F780, "ovf");

        applyStimulus(32'h1111_1100);
        repeat (FRAME - 2) @(posedge clk);
        #1;
        sample_valid = 1'b1;
        audio_in = 32'h2222_2200;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        checkOutput("coin_req", 32'(sample_req), 32'd1);
        checkOutput("coin_ovf", 32'(overflow), 32'd0);
        checkOutput("coin_under", 32'(underrun), 32'd0);
        captureFrame(1'b0, 32'h0888_8880, "coinA");
        captureFrame(1'b0, 32'h1111_1100, "coinB");

        repeat (40 * 2 * CD + CD) @(posedge clk);
        #1;
        checkOutput("mid_bclk_high", 32'(i2s_bclk), 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("abort_bclk", 32'(i2s_bclk), 32'd0);
        checkOutput("abort_lrclk", 32'(i2s_lrclk), 32'd1);
        checkOutput("abort_sdata", 32'(i2s_sdata), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        checkStartup("restart");
        captureFrame(1'b1, 32'h0000_0000, "post_rst");

        running = 1'b0;
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of the incoming signed sample bus.
REQ-002 Parameter SAMPLE_BITS, default 24: number of MSBs of each sample sent per channel; 1..31 and <= DATA_WIDTH.
REQ-003 Parameter CLK_DIV, default 4: clk cycles per bclk half-period; >= 2.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 sample_valid  input  1  one-cycle strobe; audio_in is valid this cycle.
REQ-007 audio_in  input  DATA_WIDTH  signed mono sample from the effect chain.
REQ-008 i2s_bclk  output  1  serial bit clock.
REQ-009 i2s_lrclk  output  1  word select; 0 = left, 1 = right.
REQ-010 i2s_sdata  output  1  serial data, MSB first, standard I2S (1-bclk delay after lrclk edge).
REQ-011 sample_req  output  1  one-cycle pulse at each frame start.
REQ-012 underrun  output  1  one-cycle pulse: frame started with no new sample.
REQ-013 overflow  output  1  one-cycle pulse: unconsumed pending sample overwritten.

Function
REQ-014 The block SHALL run a divider counter 0..CLK_DIV-1 and toggle i2s_bclk when the counter equals CLK_DIV-1, then wrap it to 0.
REQ-015 "Fall event" SHALL mean the clk cycle in which i2s_bclk toggles 1->0. All serial outputs SHALL change only on fall events.
REQ-016 A 6-bit slot counter (0..63) SHALL advance on each fall event and wrap 63->0. Slot 0 SHALL be the frame start.
REQ-017 i2s_lrclk SHALL be 0 in slots 0..31 and 1 in slots 32..63.
REQ-018 In channel slot c = slot mod 32, sdata SHALL output frame_reg bit [SAMPLE_BITS-c] for c = 1..SAMPLE_BITS. It SHALL output 0 for c = 0 and for c > SAMPLE_BITS.
REQ-019 Both channels SHALL carry the same frame_reg (mono duplicated to L and R).
REQ-020 The pending register SHALL capture audio_in[DATA_WIDTH-1 -: SAMPLE_BITS] on sample_valid and set pending_full.
REQ-021 At frame start with pending_full=1, the block SHALL load frame_reg from pending and clear pending_full.
REQ-022 At frame start with pending_full=0, frame_reg SHALL hold its previous value and underrun SHALL pulse.
REQ-023 sample_req SHALL pulse in the same cycle as each frame-start fall event.
REQ-024 Frame start coinciding with sample_valid: frame_reg SHALL take the old pending value, pending SHALL take the new sample, pending_full SHALL stay 1, and there SHALL be no overflow.
REQ-025 Frame start coinciding with sample_valid while pending_full=0: frame_reg SHALL take the old pending contents, underrun SHALL pulse, and the new sample SHALL be pending.
REQ-026 sample_valid with pending_full=1 and no coinciding frame start: pending SHALL be overwritten and overflow SHALL pulse.
REQ-027 Frame period SHALL be 128*CLK_DIV clk cycles; sample rate = f_clk / (128*CLK_DIV).

Reset
REQ-028 While reset=0: i2s_bclk=0, i2s_lrclk=1, i2s_sdata=0, sample_req=0, underrun=0, overflow=0; divider=0, slot=63, frame_reg=0, pending=0, pending_full=0.
REQ-029 The first fall event after reset release SHALL be a frame start (slot 63->0), occurring 2*CLK_DIV clk cycles after release.
REQ-030 Reset asserted mid-frame SHALL abort the frame immediately and return all state to REQ-028 values; a partially shifted word SHALL be discarded.

Verification
REQ-031 Release reset, CLK_DIV=4, no samples -> first sample_req and underrun at cycle 8; bclk period 8 cycles; sdata all 0; lrclk low for 256 cycles.
REQ-032 Send audio_in=32'h7FFFFF00 before frame start -> in both channels, slots 1..24 = 0111_1111_1111_1111_1111_1111 (MSB first) and slots 25..31 = 0.
REQ-033 Send 32'h80000000, then no further samples -> the next frame repeats 0x800000 with an underrun pulse.
REQ-034 Two sample_valid strobes (A then B) within one frame -> overflow pulses once, and the next frame transmits B.
REQ-035 sample_valid in the exact frame-start cycle with A pending -> frame sends A, B stays pending, no overflow, and the next frame sends B.
REQ-036 Assert reset at slot 40 mid-word -> outputs return to reset values within the same cycle, and the post-release timing matches REQ-031.
